// File: rtl/axi_host_initiator.sv
// Single-outstanding AXI4 initiator: turns one simple read/write command into
// a single-beat AXI transaction and hands back one response per command.

package axi_host_initiator_pkg;
  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

// Handshakes: every channel transfers on the rising edge where valid & ready are
// both high; a raised valid and its payload hold until that edge.
module axi_host_initiator #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 2,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned TxnId     = 0,
  parameter type req_t = axi_host_initiator_pkg::axi_req_t,
  parameter type rsp_t = axi_host_initiator_pkg::axi_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output req_t                   axi_req_o,
  input  rsp_t                   axi_rsp_i,
  output logic                   busy_o,
  output logic [2:0]             dbg_state_o
);

  localparam logic [2:0] BeatSize = 3'($clog2(DataWidth / 8));

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_e;

  state_e                 state;
  logic                   aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic                   aw_done, w_done;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth/8-1:0] strb_q;
  logic                   aw_hs, w_hs, ar_hs;
  logic                   unused_rsp;

  assign aw_hs = aw_valid & axi_rsp_i.aw_ready;
  assign w_hs  = w_valid & axi_rsp_i.w_ready;
  assign ar_hs = ar_valid & axi_rsp_i.ar_ready;
  // IDs, r.last and user bits of the response are deliberately not inspected.
  assign unused_rsp = ^axi_rsp_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      aw_valid    <= 1'b0;
      w_valid     <= 1'b0;
      ar_valid    <= 1'b0;
      b_ready     <= 1'b0;
      r_ready     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            strb_q  <= cmd_strb_i;
            if (cmd_write_i) begin
              state    <= WR_ADDR_DATA;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              ar_valid <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            w_valid <= 1'b0;
            w_done  <= 1'b1;
          end
          // Both channels may complete in the same cycle or in either order.
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state   <= WR_RESP;
            b_ready <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (axi_rsp_i.b_valid) begin
            b_ready     <= 1'b0;
            rsp_err_o   <= axi_rsp_i.b.resp[1];
            rsp_rdata_o <= '0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rsp_i.r_valid) begin
            r_ready     <= 1'b0;
            rsp_rdata_o <= axi_rsp_i.r.data;
            rsp_err_o   <= axi_rsp_i.r.resp[1];
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = IdWidth'(TxnId);
    axi_req_o.aw.addr   = addr_q;
    axi_req_o.aw.size   = BeatSize;
    axi_req_o.aw.burst  = 2'b01;
    axi_req_o.aw.user   = UserWidth'(0);
    axi_req_o.aw_valid  = aw_valid;
    axi_req_o.w.data    = wdata_q;
    axi_req_o.w.strb    = strb_q;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.w_valid   = w_valid;
    axi_req_o.b_ready   = b_ready;
    axi_req_o.ar.id     = IdWidth'(TxnId);
    axi_req_o.ar.addr   = addr_q;
    axi_req_o.ar.size   = BeatSize;
    axi_req_o.ar.burst  = 2'b01;
    axi_req_o.ar_valid  = ar_valid;
    axi_req_o.r_ready   = r_ready;
  end

endmodule

// File: tb/tb_axi_host_initiator.sv
// Bench for axi_host_initiator: memory responder with programmable ready delays,
// address-level reference memory, and a response scoreboard.
module tb_axi_host_initiator;
  import axi_host_initiator_pkg::*;

  localparam logic [47:0] ERR_BASE = 48'hFFFF_0000;
  localparam int EW = 98;  // {lat_check, accept_cycle[31:0], err, data[63:0]}

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [47:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic [7:0]  cmd_strb = '0;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic [2:0]  dbg_state;
  axi_req_t    req;
  axi_rsp_t    rsp = '0;

  int errors = 0, checks = 0, cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0] ref_mem [logic [47:0]];
  logic [63:0] mem [logic [47:0]];

  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, rsp_cnt = 0;
  int hold_cnt = 0;
  bit rand_rdy = 0, b_hold = 0;
  logic [47:0] last_aw_addr = '0, last_ar_addr = '0;

  axi_host_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .axi_req_o(req), .axi_rsp_i(rsp), .busy_o(busy),
    .dbg_state_o(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Memory responder: all channel decisions are made at the falling edge, so a
  // transfer "happens" at the next rising edge when valid & ready are seen here.
  initial begin
    bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, aw_prev = 0, w_prev = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [47:0] wa = '0;
    logic [63:0] wd = '0, rd = '0;
    logic [7:0]  ws = '0;
    logic [1:0]  bresp = '0, rresp = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        rsp = '0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_prev = 0; w_prev = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        continue;
      end
      rsp.b_valid = b_pend && !b_hold;
      rsp.b.resp  = bresp;
      if (rsp.b_valid && req.b_ready) begin b_pend = 0; b_cnt++; end
      rsp.r_valid = r_pend;
      rsp.r.data  = rd;
      rsp.r.resp  = rresp;
      rsp.r.last  = 1'b1;
      if (rsp.r_valid && req.r_ready) r_pend = 0;

      if (aw_prev) chk("aw_valid_drop", 64'(req.aw_valid), 0);
      if (w_prev)  chk("w_valid_drop", 64'(req.w_valid), 0);
      if (req.aw_valid) begin rsp.aw_ready = (aw_wait >= aw_delay); aw_wait++; end
      else begin rsp.aw_ready = 0; aw_wait = 0; end
      aw_prev = req.aw_valid && rsp.aw_ready;
      if (aw_prev) begin
        chk("aw_len", 64'(req.aw.len), 0);
        chk("aw_size", 64'(req.aw.size), 3);
        chk("aw_burst", 64'(req.aw.burst), 1);
        chk("aw_id", 64'(req.aw.id), 0);
        wa = req.aw.addr; last_aw_addr = wa; aw_got = 1; aw_wait = 0; aw_cnt++;
      end
      if (req.w_valid) begin rsp.w_ready = (w_wait >= w_delay); w_wait++; end
      else begin rsp.w_ready = 0; w_wait = 0; end
      w_prev = req.w_valid && rsp.w_ready;
      if (w_prev) begin
        chk("w_last", 64'(req.w.last), 1);
        wd = req.w.data; ws = req.w.strb; w_got = 1; w_wait = 0; w_cnt++;
      end
      if (aw_got && w_got) begin
        if (wa >= ERR_BASE) bresp = 2'b11;
        else begin
          bresp = 2'b00;
          mem[wa] = merge(mem.exists(wa) ? mem[wa] : 64'h0, wd, ws);
        end
        b_pend = 1; aw_got = 0; w_got = 0;
      end

      if (req.ar_valid) begin rsp.ar_ready = (ar_wait >= ar_delay); ar_wait++; end
      else begin rsp.ar_ready = 0; ar_wait = 0; end
      if (req.ar_valid && rsp.ar_ready) begin
        chk("ar_size", 64'(req.ar.size), 3);
        chk("ar_len", 64'(req.ar.len), 0);
        last_ar_addr = req.ar.addr; ar_wait = 0;
        if (req.ar.addr >= ERR_BASE) begin rresp = 2'b11; rd = '0; end
        else begin
          rresp = 2'b00;
          rd = mem.exists(req.ar.addr) ? mem[req.ar.addr] : 64'h0;
        end
        r_pend = 1;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    bit have_first = 0;
    int first_cyc = 0;
    logic [63:0] first_data = '0;
    logic first_err = 0;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin have_first = 0; continue; end
      if (!rsp_valid) begin rsp_ready = 1'b1; continue; end
      if (!have_first) begin
        have_first = 1; first_cyc = cyc; first_data = rsp_rdata; first_err = rsp_err;
      end else begin
        chk("rsp_data_stable", rsp_rdata, first_data);
        chk("rsp_err_stable", 64'(rsp_err), 64'(first_err));
      end
      chk("cmd_ready_in_resp", 64'(cmd_ready), 0);
      chk("busy_in_resp", 64'(busy), 1);
      if (hold_cnt > 0) begin rsp_ready = 1'b0; hold_cnt--; end
      else if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      else rsp_ready = 1'b1;
      if (rsp_ready) begin
        have_first = 0;
        rsp_cnt++;
        if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[63:0]);
          chk("rsp_err", 64'(rsp_err), 64'(e[64]));
          if (e[97]) chk("rsp_latency", 64'(first_cyc - int'(e[96:65])), 3);
        end
      end
    end
  end

  // Driver: presents a command, and at acceptance records the reference result.
  task automatic issue(input logic wr, input logic [47:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic lat);
    int n = 0;
    logic err;
    logic [63:0] data;
    @(negedge clk_i);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin @(negedge clk_i); n++; end
    if (n >= 300) begin
      chk("cmd_accept_timeout", 1, 0);
      cmd_valid = 1'b0;
      return;
    end
    err = (a >= ERR_BASE);
    data = '0;
    if (wr) begin
      if (!err) ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 64'h0, d, s);
    end else if (!err && ref_mem.exists(a)) data = ref_mem[a];
    exp_q.push_back({lat, 32'(cyc), err, data});
    @(posedge clk_i);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin @(negedge clk_i); n++; end
    if (n >= 400) chk("completion_timeout", 1, 0);
  endtask

  initial begin
    int a0, w0, b0, r0;
    // Reset
    repeat (3) @(negedge clk_i);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_cmd_ready", 64'(cmd_ready), 1);
    chk("reset_state", 64'(dbg_state), 0);
    chk("reset_valids", 64'({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}), 0);
    rst_ni = 1'b1;

    // Directed write / read with zero-wait memory
    issue(1, 48'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1);
    wait_done();
    chk("mem_readback", mem.exists(48'h1000) ? mem[48'h1000] : 64'h0, 64'hDEADBEEF_CAFEF00D);
    chk("aw_addr", 64'(last_aw_addr), 64'h1000);
    issue(0, 48'h1000, '0, '0, 1);
    wait_done();
    chk("ar_addr", 64'(last_ar_addr), 64'h1000);

    // Independent AW/W completion, both orders
    for (int k = 0; k < 2; k++) begin
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; r0 = rsp_cnt;
      aw_delay = (k == 0) ? 5 : 0;
      w_delay  = (k == 0) ? 0 : 5;
      issue(1, 48'h1008 + 48'(k * 8), {$urandom, $urandom}, 8'hFF, 0);
      wait_done();
      chk("delay_aw_count", 64'(aw_cnt - a0), 1);
      chk("delay_w_count", 64'(w_cnt - w0), 1);
      chk("delay_b_count", 64'(b_cnt - b0), 1);
      chk("delay_rsp_count", 64'(rsp_cnt - r0), 1);
    end
    aw_delay = 0; w_delay = 0;
    issue(0, 48'h1008, '0, '0, 0);

    // Decode error then a normal read
    issue(0, ERR_BASE, '0, '0, 0);
    issue(0, 48'h1000, '0, '0, 0);

    // Response back-pressure
    hold_cnt = 10;
    issue(0, 48'h1000, '0, '0, 0);
    wait_done();
    chk("hold_consumed", 64'(hold_cnt), 0);

    // Randomized traffic
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      issue($urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? ERR_BASE : 48'h2000 + 48'(8 * $urandom_range(0, 7)),
            {$urandom, $urandom}, 8'($urandom_range(0, 255)), 0);
    end
    wait_done();
    rand_rdy = 0; aw_delay = 0; w_delay = 0; ar_delay = 0;

    // Reset while waiting for B
    b_hold = 1;
    issue(1, 48'h3000, 64'h0123_4567_89AB_CDEF, 8'h0F, 0);
    begin
      int n = 0;
      while (!req.b_ready && n < 50) begin @(negedge clk_i); n++; end
      chk("reach_wr_resp", 64'(req.b_ready), 1);
    end
    repeat (2) @(negedge clk_i);
    r0 = rsp_cnt;
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_rsp_valid", 64'(rsp_valid), 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_err", 64'(rsp_err), 0);
    chk("abort_valids", 64'({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}), 0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    exp_q.delete();
    b_hold = 0;
    #1 chk("cmd_ready_after_reset", 64'(cmd_ready), 1);
    issue(0, 48'h3000, '0, '0, 1);
    wait_done();
    chk("post_reset_rsp_count", 64'(rsp_cnt - r0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
